// File: rtl/sram_arbiter_pkg.sv
// Shared types for the SRAM arbiter: port IDs, FSM states and defaults.
package sram_arbiter_pkg;

    typedef enum logic [1:0] {
        PORT_NONE = 2'd0,
        PORT_I    = 2'd1,
        PORT_D    = 2'd2,
        PORT_X    = 2'd3
    } port_e;

    typedef enum logic {
        ST_ARB    = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    localparam int unsigned STARVE_MAX_DEF = 4;

    // Bit positions inside the request/grant vectors.
    localparam int unsigned GNT_I = 0;
    localparam int unsigned GNT_D = 1;
    localparam int unsigned GNT_X = 2;

endpackage

// File: rtl/sram_arb_grant.sv
// Combinational priority grant: x > d > i, with i promoted over d when starved.
module sram_arb_grant
    import sram_arbiter_pkg::*;
(
    input  logic [2:0] req,
    input  state_e     state,
    input  logic       starve,
    output logic [2:0] gnt
);

    always_comb begin
        gnt = '0;
        if (state == ST_LOCKED) begin
            gnt[GNT_X] = req[GNT_X];
        end else if (req[GNT_X]) begin
            gnt[GNT_X] = 1'b1;
        end else if (req[GNT_I] && starve) begin
            gnt[GNT_I] = 1'b1;
        end else if (req[GNT_D]) begin
            gnt[GNT_D] = 1'b1;
        end else if (req[GNT_I]) begin
            gnt[GNT_I] = 1'b1;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Three-port single-SRAM arbiter with fetch anti-starvation, loader bus lock
// and a one-cycle read-return pipeline.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,

    input  logic              x_req,
    input  logic              x_lock,
    input  logic              x_we,
    input  logic [ADDR_W-1:0] x_addr,
    input  logic [DATA_W-1:0] x_wdata,
    output logic              x_gnt,
    output logic              x_rvalid,
    output logic [DATA_W-1:0] x_rdata,

    output logic              sram_en,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_data_out,
    input  logic [DATA_W-1:0] sram_data_in
);

    localparam int unsigned       CW        = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0]     CNT_MAX   = CW'(STARVE_MAX);
    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

    state_e        state, state_next, arb_state;
    logic [CW-1:0] starve_cnt, cnt_next;
    port_e         owner, owner_next;
    logic [2:0]    req, gnt;

    assign req = reset ? 3'b000 : {x_req, d_req, i_req};

    // Dropping x_lock releases the bus in the same cycle, so that cycle
    // is arbitrated with normal ARB priority.
    assign arb_state = (state == ST_LOCKED && x_lock) ? ST_LOCKED : ST_ARB;

    sram_arb_grant u_grant (
        .req    (req),
        .state  (arb_state),
        .starve (i_req && (starve_cnt == CNT_MAX)),
        .gnt    (gnt)
    );

    assign i_gnt = gnt[GNT_I];
    assign d_gnt = gnt[GNT_D];
    assign x_gnt = gnt[GNT_X];

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_ARB;
            starve_cnt <= '0;
            owner      <= PORT_NONE;
        end else begin
            state      <= state_next;
            starve_cnt <= cnt_next;
            owner      <= owner_next;
        end
    end

    always_comb begin
        state_next = arb_state;
        if (arb_state == ST_ARB && gnt[GNT_X] && x_lock)
            state_next = ST_LOCKED;
    end

    always_comb begin
        cnt_next = starve_cnt;
        if (arb_state == ST_ARB) begin
            if (gnt[GNT_I] || !i_req)
                cnt_next = '0;
            else if (gnt[GNT_D] && starve_cnt != CNT_MAX)
                cnt_next = starve_cnt + CW'(1);
        end
    end

    always_comb begin
        sram_en       = 1'b0;
        sram_we       = 1'b0;
        sram_addr     = '0;
        sram_data_out = '0;
        owner_next    = PORT_NONE;
        if (gnt[GNT_X]) begin
            sram_en       = 1'b1;
            sram_we       = x_we;
            sram_addr     = x_addr & WORD_MASK;
            sram_data_out = x_wdata;
            owner_next    = x_we ? PORT_NONE : PORT_X;
        end else if (gnt[GNT_D]) begin
            sram_en       = 1'b1;
            sram_we       = d_we;
            sram_addr     = d_addr & WORD_MASK;
            sram_data_out = d_wdata;
            owner_next    = d_we ? PORT_NONE : PORT_D;
        end else if (gnt[GNT_I]) begin
            sram_en    = 1'b1;
            sram_addr  = i_addr & WORD_MASK;
            owner_next = PORT_I;
        end
    end

    assign i_rvalid = !reset && (owner == PORT_I);
    assign d_rvalid = !reset && (owner == PORT_D);
    assign x_rvalid = !reset && (owner == PORT_X);
    assign i_rdata  = i_rvalid ? sram_data_in : '0;
    assign d_rdata  = d_rvalid ? sram_data_in : '0;
    assign x_rdata  = x_rvalid ? sram_data_in : '0;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed self-checking bench for sram_arbiter.
module tb_sram_arbiter;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              i_req, i_gnt, i_rvalid;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              d_req, d_we, d_gnt, d_rvalid;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata, d_rdata;
    logic              x_req, x_lock, x_we, x_gnt, x_rvalid;
    logic [ADDR_W-1:0] x_addr;
    logic [DATA_W-1:0] x_wdata, x_rdata;
    logic              sram_en, sram_we;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_data_out, sram_data_in;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    sram_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .STARVE_MAX (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .i_req         (i_req),
        .i_addr        (i_addr),
        .i_gnt         (i_gnt),
        .i_rvalid      (i_rvalid),
        .i_rdata       (i_rdata),
        .d_req         (d_req),
        .d_we          (d_we),
        .d_addr        (d_addr),
        .d_wdata       (d_wdata),
        .d_gnt         (d_gnt),
        .d_rvalid      (d_rvalid),
        .d_rdata       (d_rdata),
        .x_req         (x_req),
        .x_lock        (x_lock),
        .x_we          (x_we),
        .x_addr        (x_addr),
        .x_wdata       (x_wdata),
        .x_gnt         (x_gnt),
        .x_rvalid      (x_rvalid),
        .x_rdata       (x_rdata),
        .sram_en       (sram_en),
        .sram_we       (sram_we),
        .sram_addr     (sram_addr),
        .sram_data_out (sram_data_out),
        .sram_data_in  (sram_data_in)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_req = 0; i_addr = '0;
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        x_req = 0; x_lock = 0; x_we = 0; x_addr = '0; x_wdata = '0;
    endtask

    initial begin
        logic prev_d, prev_i;
        logic [DATA_W-1:0] rd;

        reset = 1;
        sram_data_in = 32'h5A5A_5A5A;
        idle_inputs();
        i_req = 1; d_req = 1; i_addr = 32'h10;
        tick();
        tick();
        check_eq("rst_i_gnt", i_gnt, 0);
        check_eq("rst_d_gnt", d_gnt, 0);
        check_eq("rst_sram_en", sram_en, 0);
        check_eq("rst_sram_addr", sram_addr, 0);
        check_eq("rst_rvalid", {i_rvalid, d_rvalid, x_rvalid}, 0);
        check_eq("rst_rdata", i_rdata | d_rdata | x_rdata, 0);

        // Single fetch read, unaligned address.
        idle_inputs();
        reset = 0;
        i_req = 1; i_addr = 32'h0000_0106;
        #1;
        check_eq("f_i_gnt", i_gnt, 1);
        check_eq("f_d_gnt", d_gnt, 0);
        check_eq("f_sram_en", sram_en, 1);
        check_eq("f_sram_addr", sram_addr, 32'h0000_0104);
        check_eq("f_sram_we", sram_we, 0);
        tick();
        i_req = 0;
        sram_data_in = 32'hE3A0_0001;
        #1;
        check_eq("f_i_rvalid", i_rvalid, 1);
        check_eq("f_i_rdata", i_rdata, 32'hE3A0_0001);
        check_eq("f_d_rvalid", d_rvalid, 0);
        check_eq("f_d_rdata", d_rdata, 0);
        check_eq("f_sram_en_idle", sram_en, 0);

        // All three request: x wins and drives the SRAM.
        tick();
        i_req = 1; d_req = 1; d_addr = 32'h40; d_wdata = 32'h1;
        x_req = 1; x_we = 1; x_addr = 32'h203; x_wdata = 32'h1111_2222;
        #1;
        check_eq("x_gnts", {x_gnt, d_gnt, i_gnt}, 3'b100);
        check_eq("x_sram_addr", sram_addr, 32'h200);
        check_eq("x_sram_we", sram_we, 1);
        check_eq("x_sram_dout", sram_data_out, 32'h1111_2222);
        tick();
        idle_inputs();
        #1;
        check_eq("x_wr_no_rvalid", {i_rvalid, d_rvalid, x_rvalid}, 0);

        // d and i both held: d,d,d,d,i repeating, with read returns.
        tick();
        d_req = 1; d_addr = 32'h80; i_req = 1; i_addr = 32'h300;
        prev_d = 0; prev_i = 0;
        for (int k = 0; k < 10; k++) begin
            sram_data_in = 32'h1000 + k;
            #1;
            check_eq($sformatf("st_d_gnt%0d", k), d_gnt, (k % 5) != 4);
            check_eq($sformatf("st_i_gnt%0d", k), i_gnt, (k % 5) == 4);
            check_eq($sformatf("st_d_rv%0d", k), d_rvalid, prev_d);
            check_eq($sformatf("st_i_rv%0d", k), i_rvalid, prev_i);
            rd = prev_d ? sram_data_in : '0;
            check_eq($sformatf("st_d_rd%0d", k), d_rdata, rd);
            prev_d = (k % 5) != 4;
            prev_i = (k % 5) == 4;
            tick();
        end
        idle_inputs();
        tick();

        // Bus lock: x holds the SRAM, d is shut out until lock drops.
        x_req = 1; x_lock = 1; x_addr = 32'h500; d_req = 1; d_addr = 32'h44;
        for (int k = 0; k < 3; k++) begin
            #1;
            check_eq($sformatf("lk_x_gnt%0d", k), x_gnt, 1);
            check_eq($sformatf("lk_d_gnt%0d", k), d_gnt, 0);
            if (k > 0) check_eq($sformatf("lk_x_rv%0d", k), x_rvalid, 1);
            tick();
        end
        x_req = 0;
        #1;
        check_eq("lk_idle_gnts", {x_gnt, d_gnt, i_gnt}, 3'b000);
        check_eq("lk_idle_en", sram_en, 0);
        tick();
        x_lock = 0;
        #1;
        check_eq("unlk_d_gnt", d_gnt, 1);
        check_eq("unlk_addr", sram_addr, 32'h44);
        tick();
        idle_inputs();
        tick();

        // Data write: no read return.
        d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF;
        #1;
        check_eq("w_d_gnt", d_gnt, 1);
        check_eq("w_sram_we", sram_we, 1);
        check_eq("w_sram_addr", sram_addr, 32'h40);
        check_eq("w_sram_dout", sram_data_out, 32'hDEAD_BEEF);
        tick();
        idle_inputs();
        #1;
        check_eq("w_no_d_rvalid", d_rvalid, 0);

        // Reset right after a read grant kills the return.
        tick();
        i_req = 1; i_addr = 32'h8;
        #1;
        check_eq("rr_i_gnt", i_gnt, 1);
        tick();
        reset = 1; i_req = 0; d_req = 1; d_addr = 32'h14;
        sram_data_in = 32'hAAAA_5555;
        #1;
        check_eq("rr_i_rvalid", i_rvalid, 0);
        check_eq("rr_i_rdata", i_rdata, 0);
        check_eq("rr_d_gnt", d_gnt, 0);
        check_eq("rr_sram_en", sram_en, 0);
        check_eq("rr_sram_addr", sram_addr, 0);
        tick();
        reset = 0;
        #1;
        check_eq("rr_post_d_gnt", d_gnt, 1);
        check_eq("rr_post_addr", sram_addr, 32'h14);
        check_eq("rr_post_i_rv", i_rvalid, 0);
        tick();
        idle_inputs();
        sram_data_in = 32'h0BAD_F00D;
        #1;
        check_eq("rr_post_d_rv", d_rvalid, 1);
        check_eq("rr_post_d_rd", d_rdata, 32'h0BAD_F00D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter ADDR_W, 32, SRAM word-address/byte-address width.
REQ-002 Parameter DATA_W, 32, data width.
REQ-003 Parameter STARVE_MAX, 4, consecutive data-port grants allowed while fetch is waiting.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 i_req / i_addr  input  1 / ADDR_W  fetch-port read request and byte address.
REQ-007 i_gnt / i_rvalid / i_rdata  output  1 / 1 / DATA_W  fetch grant, read-return strobe, read data.
REQ-008 d_req / d_we / d_addr / d_wdata  input  1 / 1 / ADDR_W / DATA_W  data-port request, write enable, byte address, write data.
REQ-009 d_gnt / d_rvalid / d_rdata  output  1 / 1 / DATA_W  data grant, read-return strobe, read data.
REQ-010 x_req / x_lock / x_we / x_addr / x_wdata  input  1 / 1 / 1 / ADDR_W / DATA_W  loader/debug port request, bus lock, write enable, address, write data.
REQ-011 x_gnt / x_rvalid / x_rdata  output  1 / 1 / DATA_W  loader grant, read-return strobe, read data.
REQ-012 sram_en / sram_we / sram_addr / sram_data_out  output  1 / 1 / ADDR_W / DATA_W  SRAM access strobe, write enable, word-aligned address, write data.
REQ-013 sram_data_in  input  DATA_W  SRAM read data, valid exactly one cycle after a read with sram_en=1.

Function
REQ-014 The block SHALL grant at most one port per cycle; gnt is combinational from req and state and means the request is accepted that cycle.
REQ-015 In state ARB, priority SHALL be x > d > i, except when i_req=1 and starve_cnt==STARVE_MAX, in which case i SHALL win over d (x still wins over both).
REQ-016 starve_cnt SHALL increment (saturating at STARVE_MAX) on each d grant while i_req=1, and clear to 0 on any i grant or any cycle with i_req=0.
REQ-017 On a grant, sram_en=1, sram_addr = granted addr with bits [1:0] forced to 0, sram_we = granted port's we (always 0 for i), sram_data_out = granted wdata; with no grant, sram_en=0, sram_we=0, addr/data=0.
REQ-018 For a granted read, the owner SHALL be registered and exactly one cycle later the owner's rvalid=1 with rdata=sram_data_in; writes SHALL produce no rvalid.
REQ-019 rdata of non-owners SHALL be 0; at most one rvalid SHALL be high per cycle.
REQ-020 Back-to-back grants every cycle SHALL be supported (throughput 1 access/cycle, read latency 1).
REQ-021 FSM states ARB, LOCKED: ARB->LOCKED when x is granted with x_lock=1; LOCKED->ARB on the first cycle x_lock=0 (that cycle is arbitrated as ARB).
REQ-022 In LOCKED only x SHALL be granted (x_gnt=x_req); i_gnt=d_gnt=0; starve_cnt SHALL hold.
REQ-023 Requesters SHALL hold req/addr/wdata/we stable until gnt; the arbiter needs no buffering of unaccepted requests.

Reset
REQ-024 While reset=1: all gnt, rvalid, sram_en, sram_we = 0; all rdata, sram_addr, sram_data_out = 0; state=ARB; starve_cnt=0; owner=none.
REQ-025 Reset asserted the cycle after a read grant SHALL suppress that read's rvalid.

Structure
REQ-026 Shared package SHALL hold the port-ID enum (NONE, I, D, X), the FSM state enum and the STARVE_MAX default.
REQ-027 The priority/starvation grant logic SHALL be a sub-module sram_arb_grant (combinational, inputs req vector, state, starve flag; output one-hot grant); counter, FSM and return pipeline stay in sram_arbiter.

Verification
REQ-028 Only i_req=1, i_addr=0x0000_0106 -> same cycle i_gnt=1, sram_addr=0x0000_0104, sram_we=0; next cycle i_rvalid=1, i_rdata=sram_data_in (e.g. 0xE3A0_0001).
REQ-029 x_req, d_req, i_req all 1 -> x_gnt=1 only; SRAM driven by x port.
REQ-030 d_req and i_req held 1 continuously -> d granted 4 cycles, i granted 5th, pattern repeats (starve_cnt 0..4 then clear).
REQ-031 x_req=1, x_lock=1 for 3 cycles with d_req=1 -> d_gnt=0 throughout; first cycle x_lock=0 and x_req=0 -> d_gnt=1.
REQ-032 d_we=1, d_addr=0x40, d_wdata=0xDEAD_BEEF -> sram_we=1, sram_data_out=0xDEAD_BEEF, no d_rvalid next cycle.
REQ-033 Read granted, reset=1 next cycle -> no rvalid; all outputs 0; after release first request arbitrates normally.
